// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the contador_ctrl step sequencer: controller state
// encoding, field widths and the 8-entry output sequence table.
// No ports (package).
// ---------------------------------------------------------------------------
package contador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int IDX_W    = 3;  // sequence index width (8 entries)
    localparam int Q_W      = 4;  // sequence value width
    localparam int NSTEPS_W = 4;  // steps-per-run input width
    localparam int REM_W    = 5;  // remaining-step counter, holds up to 16
    localparam int PRESC_W  = 4;  // prescaler, holds up to DIV-1 = 15

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [7:0][Q_W-1:0] SEQ_TABLE = {
        4'b1000, 4'b1100, 4'b1110, 4'b1111,
        4'b0111, 4'b0011, 4'b0001, 4'b0000
    };

    function automatic logic [Q_W-1:0] seq_value(input logic [IDX_W-1:0] i);
        return SEQ_TABLE[i];
    endfunction

endpackage

// File: rtl/contador_seq.sv
// ---------------------------------------------------------------------------
// contador_seq
// Sequence index register plus table lookup. The index advances by one
// (wrapping 7->0) on each cycle with step=1 and returns to 0 on clr=1.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (index -> 0)
//   step  in   advance the index this cycle
//   clr   in   force the index to 0 this cycle (wins over step)
//   idx   out  current index
//   q     out  SEQ_TABLE[idx]
// ---------------------------------------------------------------------------
module contador_seq
    import contador_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic [Q_W-1:0]   q
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (step) begin
            // Natural 3-bit overflow gives the 7->0 wrap.
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;
    assign q   = seq_value(idx_q);

endmodule

// File: rtl/contador_ctrl.sv
// ---------------------------------------------------------------------------
// contador_ctrl
// Run controller for a prescaled step sequencer. A run of nsteps steps
// (0 means 16) starts from IDLE on start; every DIV clocks in RUN a step
// strobe advances the sequence index. pause holds the run, stop aborts it
// without a done pulse. The index is not reset by start, so runs continue
// the sequence; clr in IDLE returns it to 0.
// Parameters:
//   DIV     clock cycles per step (1..16)
// Ports:
//   C       in   clock, rising edge
//   R       in   asynchronous active-high reset
//   start   in   begin a run (IDLE only)
//   stop    in   abort the run (RUN/PAUSE), has priority over pause
//   pause   in   level, holds the run while high
//   clr     in   clear the sequence index (IDLE only)
//   nsteps  in   steps per run, latched at start; 0 means 16
//   step    out  one-cycle advance strobe (combinational)
//   Q       out  current sequence value
//   idx     out  current sequence index
//   busy    out  high in RUN or PAUSE
//   done    out  one-cycle pulse after a run completes normally
// ---------------------------------------------------------------------------
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic       C,
    input  logic       R,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       clr,
    input  logic [3:0] nsteps,
    output logic       step,
    output logic [3:0] Q,
    output logic [2:0] idx,
    output logic       busy,
    output logic       done
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [REM_W-1:0]   rem_q,   rem_d;
    logic               step_int;
    logic               clr_seq;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        rem_d    = rem_q;
        step_int = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    rem_d   = (nsteps == '0) ? REM_W'(16) : {1'b0, nsteps};
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (pause) begin
                    // Prescaler holds so no strobe is lost across the pause.
                    state_d = ST_PAUSE;
                end else begin
                    step_int = (presc_q == PRESC_MAX);
                    presc_d  = step_int ? '0 : presc_q + PRESC_W'(1);
                    if (step_int) begin
                        rem_d = rem_q - REM_W'(1);
                        if (rem_q == REM_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                // A start arriving here is deliberately dropped.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
        end
    end

    // clr only acts in IDLE; with start it still applies, so the run begins at 0.
    assign clr_seq = (state_q == ST_IDLE) && clr;

    contador_seq u_seq (
        .clk  (C),
        .rst  (R),
        .step (step_int),
        .clr  (clr_seq),
        .idx  (idx),
        .q    (Q)
    );

    assign step = step_int;
    assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_contador_ctrl.sv
// ---------------------------------------------------------------------------
// tb_contador_ctrl
// Self-checking bench for contador_ctrl. One instance with DIV=2 carries most
// scenarios; a second with DIV=4 carries the pause scenario. Expected sequence
// values are pushed to a queue when a run is started and compared against the
// values captured after each observed step.
// ---------------------------------------------------------------------------
module tb_contador_ctrl;

    logic       C = 1'b0;
    logic       R;

    logic       start2, stop2, pause2, clr2;
    logic [3:0] ns2;
    logic       step2, busy2, done2;
    logic [3:0] q2;
    logic [2:0] idx2;

    logic       start4, stop4, pause4, clr4;
    logic [3:0] ns4;
    logic       step4, busy4, done4;
    logic [3:0] q4;
    logic [2:0] idx4;

    contador_ctrl #(.DIV(2)) dut2 (
        .C(C), .R(R), .start(start2), .stop(stop2), .pause(pause2), .clr(clr2),
        .nsteps(ns2), .step(step2), .Q(q2), .idx(idx2), .busy(busy2), .done(done2)
    );

    contador_ctrl #(.DIV(4)) dut4 (
        .C(C), .R(R), .start(start4), .stop(stop4), .pause(pause4), .clr(clr4),
        .nsteps(ns4), .step(step4), .Q(q4), .idx(idx4), .busy(busy4), .done(done4)
    );

    always #5 C = ~C;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    int m_idx;

    function automatic logic [3:0] seq_of(input int i);
        case (i % 8)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0011;
            3: return 4'b0111;
            4: return 4'b1111;
            5: return 4'b1110;
            6: return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    // Starts a run on the DIV=2 instance, pushes expected values, captures Q
    // after each step until done or the cycle budget runs out.
    task automatic do_run(input int n, input bit with_clr,
                          output int steps, output int dones, output bit timed_out);
        logic pend;
        int   cnt;
        steps = 0; dones = 0; timed_out = 1'b1; pend = 1'b0;
        cnt = (n == 0) ? 16 : n;
        @(negedge C);
        start2 = 1'b1; clr2 = with_clr; ns2 = 4'(n);
        if (with_clr) m_idx = 0;
        for (int s = 0; s < cnt; s++) begin
            m_idx = (m_idx + 1) % 8;
            exp_q.push_back(seq_of(m_idx));
        end
        @(negedge C);
        start2 = 1'b0; clr2 = 1'b0;
        #1;
        for (int k = 0; k < 200; k++) begin
            if (pend) got_q.push_back(q2);
            pend = step2;
            if (step2) steps++;
            if (done2) begin
                dones++;
                timed_out = 1'b0;
                break;
            end
            @(negedge C);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge C);
        #1;
        checks++; if (q2 !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", q2); end
        checks++; if (idx2 !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx2); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy2); end
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done2); end
        checks++; if (step2 !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step2); end
        checks++; if (q4 !== 4'b0000) begin failures++; $display("FAIL reset_q4 got=%b exp=0000", q4); end
        R = 1'b0;
        $display("reset released");
    endtask

    task automatic test_basic();
        logic pend;
        logic e_step, e_busy, e_done;
        logic [3:0] e;
        m_idx = 0;
        pend = 1'b0;
        @(negedge C);
        start2 = 1'b1; ns2 = 4'd3;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0011); exp_q.push_back(4'b0111);
        m_idx = 3;
        @(negedge C);
        start2 = 1'b0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            e_step = (k == 2) || (k == 4) || (k == 6);
            e_busy = (k <= 6);
            e_done = (k == 7);
            checks++; if (step2 !== e_step) begin failures++; $display("FAIL basic_step c%0d got=%b exp=%b", k, step2, e_step); end
            checks++; if (busy2 !== e_busy) begin failures++; $display("FAIL basic_busy c%0d got=%b exp=%b", k, busy2, e_busy); end
            checks++; if (done2 !== e_done) begin failures++; $display("FAIL basic_done c%0d got=%b exp=%b", k, done2, e_done); end
            if (pend) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
                checks++; if (q2 !== e) begin failures++; $display("FAIL basic_q c%0d got=%b exp=%b", k, q2, e); end
            end
            pend = step2;
            @(negedge C);
            #1;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("basic run nsteps=3 idx=%0d", idx2);
    endtask

    task automatic test_wrap();
        int steps, dones;
        bit to;
        logic [3:0] e, g;
        do_run(3, 1'b0, steps, dones, to);   // idx 3 -> 6
        checks++; if (to) begin failures++; $display("FAIL wrap_pre_timeout got=1 exp=0"); end
        do_run(4, 1'b0, steps, dones, to);   // idx 6 -> 2, wraps through 7->0
        checks++; if (to) begin failures++; $display("FAIL wrap_timeout got=1 exp=0"); end
        checks++; if (dones != 1) begin failures++; $display("FAIL wrap_dones got=%0d exp=1", dones); end
        checks++; if (steps != 4) begin failures++; $display("FAIL wrap_steps got=%0d exp=4", steps); end
        // Last four expected entries are 1000,0000,0001,0011.
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'bxxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL wrap_q got=%b exp=%b", g, e); end
        end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL wrap_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
        // start while in DONE is dropped
        start2 = 1'b1;
        @(negedge C);
        start2 = 1'b0;
        #1;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL done_start_lost got=%b exp=0", busy2); end
        @(negedge C);
        #1;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL done_start_lost2 got=%b exp=0", busy2); end
        checks++; if (idx2 !== 3'(m_idx)) begin failures++; $display("FAIL wrap_idx got=%0d exp=%0d", idx2, m_idx); end
        $display("wrap run nsteps=4 idx=%0d", idx2);
    endtask

    task automatic test_pause();
        logic pend;
        logic e_step, e_busy, e_done;
        logic [3:0] e;
        pend = 1'b0;
        @(negedge C);
        start4 = 1'b1; ns4 = 4'd2;
        exp_q.push_back(seq_of(1)); exp_q.push_back(seq_of(2));
        @(negedge C);
        start4 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            pause4 = (k >= 3) && (k <= 7);
            #1;
            e_step = (k == 10) || (k == 14);
            e_busy = (k <= 14);
            e_done = (k == 15);
            checks++; if (step4 !== e_step) begin failures++; $display("FAIL pause_step c%0d got=%b exp=%b", k, step4, e_step); end
            checks++; if (busy4 !== e_busy) begin failures++; $display("FAIL pause_busy c%0d got=%b exp=%b", k, busy4, e_busy); end
            checks++; if (done4 !== e_done) begin failures++; $display("FAIL pause_done c%0d got=%b exp=%b", k, done4, e_done); end
            if (pend) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
                checks++; if (q4 !== e) begin failures++; $display("FAIL pause_q c%0d got=%b exp=%b", k, q4, e); end
            end
            pend = step4;
            @(negedge C);
        end
        pause4 = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pause_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("pause run DIV=4 idx=%0d", idx4);
    endtask

    task automatic test_stop();
        logic e_step, e_busy;
        logic [2:0] e_idx;
        @(negedge C);
        start2 = 1'b1; ns2 = 4'd5;
        @(negedge C);
        start2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            stop2 = (k == 4);
            #1;
            e_step = (k == 2);
            e_busy = (k <= 4);
            checks++; if (step2 !== e_step) begin failures++; $display("FAIL stop_step c%0d got=%b exp=%b", k, step2, e_step); end
            checks++; if (busy2 !== e_busy) begin failures++; $display("FAIL stop_busy c%0d got=%b exp=%b", k, busy2, e_busy); end
            checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL stop_done c%0d got=%b exp=0", k, done2); end
            if (k >= 3) begin
                e_idx = 3'((m_idx + 1) % 8);
                checks++; if (idx2 !== e_idx) begin failures++; $display("FAIL stop_idx c%0d got=%0d exp=%0d", k, idx2, e_idx); end
            end
            @(negedge C);
        end
        stop2 = 1'b0;
        m_idx = (m_idx + 1) % 8;
        $display("stop run idx=%0d", idx2);
    endtask

    task automatic test_full16();
        int steps, dones, s;
        bit to;
        logic [3:0] e, g;
        s = m_idx;
        do_run(0, 1'b0, steps, dones, to);
        checks++; if (to) begin failures++; $display("FAIL full_timeout got=1 exp=0"); end
        checks++; if (steps != 16) begin failures++; $display("FAIL full_steps got=%0d exp=16", steps); end
        checks++; if (dones != 1) begin failures++; $display("FAIL full_dones got=%0d exp=1", dones); end
        checks++; if (idx2 !== 3'(s)) begin failures++; $display("FAIL full_idx got=%0d exp=%0d", idx2, s); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'bxxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL full_q got=%b exp=%b", g, e); end
        end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL full_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
        $display("full run nsteps=0 steps=%0d idx=%0d", steps, idx2);
    endtask

    task automatic test_clr_start();
        int steps, dones;
        bit to;
        logic [3:0] e, g;
        do_run(1, 1'b1, steps, dones, to);
        checks++; if (to) begin failures++; $display("FAIL clr_timeout got=1 exp=0"); end
        checks++; if (idx2 !== 3'd1) begin failures++; $display("FAIL clr_idx got=%0d exp=1", idx2); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'bxxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL clr_q got=%b exp=%b", g, e); end
        end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL clr_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
        $display("clr+start run idx=%0d", idx2);
    endtask

    task automatic test_reset_midrun();
        int steps, dones;
        bit to;
        logic [3:0] e, g;
        @(negedge C);
        start2 = 1'b1; ns2 = 4'd8;
        @(negedge C);
        start2 = 1'b0;
        repeat (3) @(negedge C);
        #2;
        R = 1'b1;
        #1;
        checks++; if (q2 !== 4'b0000) begin failures++; $display("FAIL rmid_q got=%b exp=0000", q2); end
        checks++; if (idx2 !== 3'd0) begin failures++; $display("FAIL rmid_idx got=%0d exp=0", idx2); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy2); end
        checks++; if (step2 !== 1'b0) begin failures++; $display("FAIL rmid_step got=%b exp=0", step2); end
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", done2); end
        #1;
        R = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge C);
            #1;
            checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL rmid_nodone c%0d got=%b exp=0", k, done2); end
            checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rmid_idle c%0d got=%b exp=0", k, busy2); end
        end
        m_idx = 0;
        do_run(2, 1'b0, steps, dones, to);
        checks++; if (to) begin failures++; $display("FAIL rmid_timeout got=1 exp=0"); end
        checks++; if (idx2 !== 3'd2) begin failures++; $display("FAIL rmid_after_idx got=%0d exp=2", idx2); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'bxxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL rmid_q got=%b exp=%b", g, e); end
        end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rmid_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
        $display("reset mid-run then run idx=%0d", idx2);
    endtask

    initial begin
        R = 1'b1;
        start2 = 1'b0; stop2 = 1'b0; pause2 = 1'b0; clr2 = 1'b0; ns2 = 4'd0;
        start4 = 1'b0; stop4 = 1'b0; pause4 = 1'b0; clr4 = 1'b0; ns4 = 4'd0;
        m_idx = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_pause();
        test_stop();
        test_full16();
        test_clr_start();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_ctrl.md
CONTADOR_CTRL -- requirements
Module: contador_ctrl

Interface
REQ-001 SHALL have parameter: DIV, 2, clock cycles per counter step (legal 1..16).
REQ-002 SHALL have port: C  input  1  clock, all state changes on rising edge.
REQ-003 SHALL have port: R  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  begin a run, sampled in IDLE only.
REQ-005 SHALL have port: stop  input  1  abort the run, sampled in RUN/PAUSE.
REQ-006 SHALL have port: pause  input  1  level; holds the run while high.
REQ-007 SHALL have port: clr  input  1  return sequence index to 0, sampled in IDLE only.
REQ-008 SHALL have port: nsteps  input  4  steps per run, latched at start; 0 means 16.
REQ-009 SHALL have port: step  output  1  one-cycle advance strobe.
REQ-010 SHALL have port: Q  output  4  current sequence value, SEQ[idx].
REQ-011 SHALL have port: idx  output  3  current sequence index.
REQ-012 SHALL have port: busy  output  1  high in RUN or PAUSE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse on normal run completion.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-015 SHALL use sequence table SEQ = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 (idx 0..7).
REQ-016 SHALL take IDLE->RUN on start=1, latching nsteps into a 5-bit remaining count (0 loads 16) and clearing the prescaler.
REQ-017 SHALL count the prescaler 0..DIV-1 in RUN and wrap to 0; it SHALL hold in PAUSE.
REQ-018 SHALL drive step combinationally high when state=RUN, prescaler=DIV-1, pause=0 and stop=0.
REQ-019 SHALL, on each edge with step=1, advance idx modulo 8 (7->0) and decrement remaining.
REQ-020 SHALL take RUN->DONE on the edge where step=1 and remaining=1.
REQ-021 SHALL take DONE->IDLE unconditionally after one cycle; done SHALL be 1 only in DONE.
REQ-022 SHALL take RUN->PAUSE when pause=1 and PAUSE->RUN when pause=0; stop SHALL have priority over pause.
REQ-023 SHALL take RUN/PAUSE->IDLE on stop=1 with idx retained, no done, and no step in that cycle.
REQ-024 SHALL ignore start outside IDLE; start in DONE SHALL be lost.
REQ-025 SHALL, on clr=1 in IDLE, set idx to 0; if clr and start are both 1, clr SHALL apply and the run SHALL start from idx 0.
REQ-026 SHALL not reset idx at start, so successive runs continue the sequence.

Reset
REQ-027 SHALL, on R=1 asynchronously, set state=IDLE, idx=0, prescaler=0 and remaining=0, giving Q=0000, step=0, busy=0 and done=0.
REQ-028 SHALL, on reset mid-run, abandon the run with no done pulse.

Structure
REQ-029 SHALL place the state encoding, SEQ table and width constants in shared package contador_pkg.
REQ-030 SHALL contain one sub-module, contador_seq (idx register plus SEQ lookup, advanced by step, cleared by clr).

Verification
REQ-031 SHALL cover: DIV=2, nsteps=3, idx=0, start pulse -> step in RUN cycles 2/4/6, Q=0001,0011,0111, done 1 cycle after the third step, busy for 6 cycles.
REQ-032 SHALL cover: idx=6, nsteps=4 -> Q sequence 1000,0000,0001,0011 (idx wrap 7->0), one done.
REQ-033 SHALL cover: DIV=4, pause held 5 cycles at prescaler=2 -> no step while paused; step follows 1 RUN cycle after release.
REQ-034 SHALL cover: stop asserted together with the step strobe -> no step, idx unchanged, IDLE next, no done.
REQ-035 SHALL cover: nsteps=0 -> exactly 16 steps, idx ends at its start value, one done.
REQ-036 SHALL cover: R pulsed mid-run between clock edges -> outputs go to reset values immediately; a later start runs normally from idx 0.
